// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types, constants and byte-lane merge for the data memory arbiter
package data_mem_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } arb_state_e;

   localparam int         PORT_CORE = 0;
   localparam int         PORT_DMA  = 1;
   localparam logic [3:0] BE_FULL   = 4'hF;

   // Lanes with their enable set come from the new data, the rest keep the old word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  byte_en);
      logic [31:0] merged;
      merged = old_word;
      for (int k = 0; k < 4; k++) begin
         if (byte_en[k]) begin
            merged[8*k +: 8] = new_word[8*k +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester handshake, response and DataMemory signals of the arbiter
interface data_mem_arbiter_if #(
   parameter int AW = 32
);
   logic [1:0]         i_Req_Valid;
   logic [1:0]         o_Req_Ready;
   logic [1:0]         i_Req_wEnable;
   logic [1:0][AW-1:0] i_Req_Addr;
   logic [1:0][3:0]    i_Req_ByteEn;
   logic [1:0][31:0]   i_Req_wData;
   logic [1:0]         o_Rsp_Valid;
   logic [31:0]        o_Rsp_rData;
   logic               o_Rsp_Err;
   logic               o_Mem_wEnable;
   logic [31:0]        o_Mem_Addr;
   logic [31:0]        o_Mem_wData;
   logic [31:0]        i_Mem_rData;

   modport slave (
      input  i_Req_Valid, i_Req_wEnable, i_Req_Addr, i_Req_ByteEn, i_Req_wData, i_Mem_rData,
      output o_Req_Ready, o_Rsp_Valid, o_Rsp_rData, o_Rsp_Err, o_Mem_wEnable, o_Mem_Addr, o_Mem_wData
   );

   modport master (
      output i_Req_Valid, i_Req_wEnable, i_Req_Addr, i_Req_ByteEn, i_Req_wData, i_Mem_rData,
      input  o_Req_Ready, o_Rsp_Valid, o_Rsp_rData, o_Rsp_Err, o_Mem_wEnable, o_Mem_Addr, o_Mem_wData
   );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter_2.sv
// rtl/data_mem_arbiter_rr_arbiter_2.sv - two-requester round-robin grant, one-hot output
module rr_arbiter_2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   input  logic       en_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // On a tie the port that did not win last time goes first.
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares one word-wide DataMemory between core LSU and DMA/debug port,
// adding byte-enable stores through a two-cycle read-modify-write.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int MEM_WORDS = 64,
   parameter int AW        = 32
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   data_mem_arbiter_if.slave bus
);

   localparam logic [AW-3:0] MEM_LIMIT = (AW-2)'(MEM_WORDS);

   arb_state_e    state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [31:0]   cap_addr_q, cap_addr_d;
   logic [3:0]    cap_be_q, cap_be_d;
   logic [31:0]   cap_wdata_q, cap_wdata_d;
   logic [31:0]   cap_old_q, cap_old_d;
   logic          cap_port_q, cap_port_d;
   logic [1:0]    rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic [1:0]    grant;
   logic          accept;
   logic          sel_port;
   logic          sel_we;
   logic [AW-3:0] sel_word;
   logic [3:0]    sel_be;
   logic [31:0]   sel_wdata;
   logic          sel_in_range;
   logic [31:0]   sel_mem_addr;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;

   rr_arbiter_2 u_rr_arbiter (
      .req_i        (bus.i_Req_Valid),
      .last_grant_i (last_grant_q),
      .en_i         (state_q == IDLE),
      .grant_o      (grant)
   );

   assign accept       = |grant;
   assign sel_port     = grant[PORT_DMA];
   assign sel_we       = bus.i_Req_wEnable[sel_port];
   assign sel_word     = bus.i_Req_Addr[sel_port][AW-1:2];
   assign sel_be       = bus.i_Req_ByteEn[sel_port];
   assign sel_wdata    = bus.i_Req_wData[sel_port];
   assign sel_in_range = sel_word < MEM_LIMIT;
   assign sel_mem_addr = 32'({2'b00, sel_word});

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cap_addr_d   = cap_addr_q;
      cap_be_d     = cap_be_q;
      cap_wdata_d  = cap_wdata_q;
      cap_old_d    = cap_old_q;
      cap_port_d   = cap_port_q;
      rsp_valid_d  = 2'b00;
      rsp_rdata_d  = 32'h0;
      rsp_err_d    = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               last_grant_d = sel_port;
               rsp_valid_d  = grant;
               if (!sel_in_range) begin
                  rsp_err_d = 1'b1;
               end else begin
                  mem_addr = sel_mem_addr;
                  if (!sel_we) begin
                     rsp_rdata_d = bus.i_Mem_rData;
                  end else if (sel_be == BE_FULL) begin
                     mem_we    = 1'b1;
                     mem_wdata = sel_wdata;
                  end else if (sel_be != 4'h0) begin
                     // Partial store: hold the old word now, write the merge next cycle.
                     rsp_valid_d = 2'b00;
                     cap_addr_d  = sel_mem_addr;
                     cap_be_d    = sel_be;
                     cap_wdata_d = sel_wdata;
                     cap_old_d   = bus.i_Mem_rData;
                     cap_port_d  = sel_port;
                     state_d     = RMW_WR;
                  end
               end
            end
         end
         RMW_WR: begin
            mem_we      = 1'b1;
            mem_addr    = cap_addr_q;
            mem_wdata   = merge_bytes(cap_old_q, cap_wdata_q, cap_be_q);
            rsp_valid_d = cap_port_q ? 2'(1 << PORT_DMA) : 2'(1 << PORT_CORE);
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cap_addr_q   <= 32'h0;
         cap_be_q     <= 4'h0;
         cap_wdata_q  <= 32'h0;
         cap_old_q    <= 32'h0;
         cap_port_q   <= 1'b0;
         rsp_valid_q  <= 2'b00;
         rsp_rdata_q  <= 32'h0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cap_addr_q   <= cap_addr_d;
         cap_be_q     <= cap_be_d;
         cap_wdata_q  <= cap_wdata_d;
         cap_old_q    <= cap_old_d;
         cap_port_q   <= cap_port_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.o_Req_Ready   = grant;
   assign bus.o_Rsp_Valid   = rsp_valid_q;
   assign bus.o_Rsp_rData   = rsp_rdata_q;
   assign bus.o_Rsp_Err     = rsp_err_q;
   // Reset kills an in-flight RMW write immediately, not at the next edge.
   assign bus.o_Mem_wEnable = mem_we & i_Reset;
   assign bus.o_Mem_Addr    = mem_addr;
   assign bus.o_Mem_wData   = mem_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
   localparam int MEM_WORDS = 64;
   localparam int AW        = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_arbiter_if #(.AW(AW)) bus ();

   data_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
      .i_Clk   (clk),
      .i_Reset (rst_n),
      .bus     (bus)
   );

   logic [31:0] tb_mem  [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   logic        preload = 1'b0;
   int          cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] <= ref_mem[i];
      end else if (bus.o_Mem_wEnable && bus.o_Mem_Addr < 32'(MEM_WORDS)) begin
         tb_mem[bus.o_Mem_Addr[5:0]] <= bus.o_Mem_wData;
      end
   end

   always_comb begin
      bus.i_Mem_rData = 32'hBAD0_BAD0;
      if (bus.o_Mem_Addr < 32'(MEM_WORDS)) bus.i_Mem_rData = tb_mem[bus.o_Mem_Addr[5:0]];
   end

   typedef struct {
      int          due;
      int          port;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t             q[$];
   int               n_checks = 0;
   int               n_errors = 0;
   int               last_g   = 1;
   int               rmw_due  = -1;
   int               rmw_word = 0;
   logic [31:0]      rmw_val  = 0;
   logic [1:0]       last_acc = 0;
   logic [1:0]       pend_valid = 0;
   logic [1:0]       pend_we    = 0;
   logic [1:0][31:0] pend_addr  = 0;
   logic [1:0][3:0]  pend_be    = 0;
   logic [1:0][31:0] pend_wdata = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive();
      bus.i_Req_Valid   = pend_valid;
      bus.i_Req_wEnable = pend_we;
      bus.i_Req_Addr    = pend_addr;
      bus.i_Req_ByteEn  = pend_be;
      bus.i_Req_wData   = pend_wdata;
   endtask

   task automatic issue(input int p, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      pend_valid[p] = 1'b1;
      pend_we[p]    = we;
      pend_addr[p]  = addr;
      pend_be[p]    = be;
      pend_wdata[p] = wd;
   endtask

   // Expected effect of one accepted request, from the functional rules only.
   task automatic model_accept(input int p);
      logic [29:0] w;
      logic [31:0] mask;
      w = pend_addr[p][31:2];
      if (w >= 30'(MEM_WORDS)) begin
         chk("oor_no_write", bus.o_Mem_wEnable, 0);
         q.push_back('{cyc + 1, p, 32'h0, 1'b1});
      end else if (!pend_we[p]) begin
         chk("load_addr", bus.o_Mem_Addr, 64'(w));
         q.push_back('{cyc + 1, p, ref_mem[w], 1'b0});
      end else if (pend_be[p] == 4'hF) begin
         chk("full_we", bus.o_Mem_wEnable, 1);
         chk("full_addr", bus.o_Mem_Addr, 64'(w));
         chk("full_wdata", bus.o_Mem_wData, pend_wdata[p]);
         ref_mem[w] = pend_wdata[p];
         q.push_back('{cyc + 1, p, 32'h0, 1'b0});
      end else if (pend_be[p] == 4'h0) begin
         chk("be0_no_write", bus.o_Mem_wEnable, 0);
         q.push_back('{cyc + 1, p, 32'h0, 1'b0});
      end else begin
         chk("part_no_write_yet", bus.o_Mem_wEnable, 0);
         mask = 0;
         for (int k = 0; k < 4; k++) if (pend_be[p][k]) mask = mask | (32'hFF << (8 * k));
         rmw_due  = cyc + 1;
         rmw_word = int'(w);
         rmw_val  = (pend_wdata[p] & mask) | (ref_mem[w] & ~mask);
         q.push_back('{cyc + 2, p, 32'h0, 1'b0});
      end
   endtask

   task automatic cycle();
      logic [1:0]  exp_v, exp_rdy, acc;
      logic [31:0] exp_d;
      logic        exp_e;
      bit          in_rmw;
      int          p;
      @(negedge clk);
      exp_v = 0; exp_d = 0; exp_e = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].due == cyc) begin
            exp_v[q[i].port] = 1'b1;
            exp_d = q[i].data;
            exp_e = q[i].err;
            q.delete(i);
         end
      end
      chk("rsp_valid", bus.o_Rsp_Valid, exp_v);
      if (exp_v != 0) begin
         chk("rsp_rdata", bus.o_Rsp_rData, exp_d);
         chk("rsp_err", bus.o_Rsp_Err, exp_e);
      end
      in_rmw = (cyc == rmw_due);
      drive();
      #1;
      exp_rdy = 2'b00;
      if (!in_rmw) begin
         case (pend_valid)
            2'b01:   exp_rdy = 2'b01;
            2'b10:   exp_rdy = 2'b10;
            2'b11:   exp_rdy = (last_g == 1) ? 2'b01 : 2'b10;
            default: exp_rdy = 2'b00;
         endcase
      end
      chk("req_ready", bus.o_Req_Ready, exp_rdy);
      acc      = pend_valid & bus.o_Req_Ready;
      last_acc = acc;
      if (in_rmw) begin
         chk("rmw_we", bus.o_Mem_wEnable, 1);
         chk("rmw_addr", bus.o_Mem_Addr, 64'(rmw_word));
         chk("rmw_wdata", bus.o_Mem_wData, rmw_val);
         ref_mem[rmw_word] = rmw_val;
         rmw_due = -1;
      end else if (acc == 2'b00) begin
         chk("idle_we", bus.o_Mem_wEnable, 0);
         chk("idle_addr_wdata", {bus.o_Mem_Addr, bus.o_Mem_wData}, 0);
      end else begin
         p = acc[1] ? 1 : 0;
         last_g = p;
         model_accept(p);
         pend_valid[p] = 1'b0;
      end
   endtask

   task automatic wait_acc(input int p);
      int n = 0;
      while (pend_valid[p] && n < 20) begin
         cycle();
         n++;
      end
      chk("accepted", pend_valid[p], 0);
      pend_valid[p] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      pend_valid = 2'b00;
      drive();
      #1;
      chk("rst_rsp_valid", bus.o_Rsp_Valid, 0);
      chk("rst_rsp_rdata", bus.o_Rsp_rData, 0);
      chk("rst_rsp_err", bus.o_Rsp_Err, 0);
      chk("rst_mem_we", bus.o_Mem_wEnable, 0);
      q.delete();
      rmw_due = -1;
      last_g  = 1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] saved;
      logic [31:0] a;
      int          w;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
      ref_mem[2] = 32'h1234_5678;
      drive();
      preload = 1'b1;
      @(posedge clk);
      @(negedge clk);
      preload = 1'b0;
      #1;
      chk("rst_rsp_valid", bus.o_Rsp_Valid, 0);
      chk("rst_rsp_rdata", bus.o_Rsp_rData, 0);
      chk("rst_rsp_err", bus.o_Rsp_Err, 0);
      chk("rst_mem_we", bus.o_Mem_wEnable, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Both ports loading continuously after reset: grants alternate starting at port 0.
      for (int k = 0; k < 4; k++) begin
         if (!pend_valid[0]) issue(0, 1'b0, 32'h0000_0020, 4'h0, 32'h0);
         if (!pend_valid[1]) issue(1, 1'b0, 32'h0000_0030, 4'h0, 32'h0);
         cycle();
         chk("alt_grant", last_acc, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      pend_valid = 2'b00;
      repeat (2) cycle();

      issue(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
      wait_acc(0);
      issue(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
      wait_acc(0);
      cycle();
      chk("t1_word4", tb_mem[4], 32'hDEAD_BEEF);

      issue(1, 1'b1, 32'h0000_0010, 4'b0001, 32'h0000_00AA);
      wait_acc(1);
      cycle();
      cycle();
      chk("t2_word4", tb_mem[4], 32'hDEAD_BEAA);

      issue(0, 1'b0, 32'h0000_0100, 4'h0, 32'h0);
      wait_acc(0);
      cycle();

      issue(0, 1'b1, 32'h0000_0008, 4'h0, 32'hFFFF_FFFF);
      wait_acc(0);
      cycle();
      chk("be0_word2", tb_mem[2], 32'h1234_5678);

      saved = ref_mem[6];
      issue(1, 1'b1, 32'h0000_0018, 4'b0110, 32'h5555_5555);
      wait_acc(1);
      do_reset();
      chk("rst_rmw_word6", tb_mem[6], saved);
      issue(1, 1'b0, 32'h0000_0018, 4'h0, 32'h0);
      wait_acc(1);
      cycle();

      for (int n = 0; n < 1500; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend_valid[p] && $urandom_range(0, 2) != 0) begin
               w = $urandom_range(0, 71);
               a = {30'(w), 2'($urandom)};
               if ($urandom_range(0, 15) == 0) a = $urandom;
               case ($urandom_range(0, 3))
                  0:       issue(p, 1'($urandom), a, 4'hF, $urandom);
                  1:       issue(p, 1'($urandom), a, 4'h0, $urandom);
                  default: issue(p, 1'($urandom), a, 4'($urandom), $urandom);
               endcase
            end
         end
         cycle();
      end
      pend_valid = 2'b00;
      repeat (3) cycle();
      chk("drain", q.size(), 0);
      for (int i = 0; i < MEM_WORDS; i++) chk("mem_final", tb_mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
